// File: rtl/usb_rx_phy_ovs_pkg.sv
// Shared FSM state, line-state encodings and the bit-stuff run length for the oversampling USB receive PHY.
package usb_rx_pkg;
  typedef enum logic [1:0] {IDLE, HUNT, DATA, ERR} rxState_t;

  localparam logic [1:0] SE0  = 2'b00;
  localparam logic [1:0] J_FS = 2'b01;
  localparam logic [1:0] K_FS = 2'b10;

  localparam int STUFF_RUN = 6;
endpackage

// File: rtl/usb_rx_phy_ovs_dpll.sv
// Counter DPLL: re-phases on each synchronised Dif edge (outside SE0) and strobes mid-bit at cnt == N/2.
module usb_rx_dpll #(
  parameter int CLK_PER_BIT_FS = 4,
  parameter int CLK_PER_BIT_LS = 32
) (
  input  logic clkout2,
  input  logic reset,
  input  logic difSync,
  input  logic se0,
  input  logic lowSpeed,
  output logic strobe,
  output logic clkRecovered
);
  localparam int CW = $clog2(CLK_PER_BIT_LS);
  localparam logic [CW-1:0] HALF_FS = CW'(CLK_PER_BIT_FS / 2);
  localparam logic [CW-1:0] HALF_LS = CW'(CLK_PER_BIT_LS / 2);
  localparam logic [CW-1:0] LAST_FS = CW'(CLK_PER_BIT_FS - 1);
  localparam logic [CW-1:0] LAST_LS = CW'(CLK_PER_BIT_LS - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] half;
  logic [CW-1:0] last;
  logic          difPrev;

  assign half = lowSpeed ? HALF_LS : HALF_FS;
  assign last = lowSpeed ? LAST_LS : LAST_FS;

  // '>=' wraps cleanly when the rate drops from LS to FS with cnt beyond N-1.
  always_ff @(posedge clkout2 or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      difPrev <= 1'b0;
    end else begin
      difPrev <= difSync;
      if ((difSync != difPrev) && !se0) cnt <= CW'(1);
      else if (cnt >= last)             cnt <= '0;
      else                              cnt <= cnt + 1'b1;
    end
  end

  assign strobe       = (cnt == half);
  assign clkRecovered = (cnt >= half);
endmodule

// File: rtl/usb_rx_phy_ovs.sv
// Oversampling USB 1.1 receive PHY (FS/LS): sync, DPLL, NRZI decode, destuff, SYNC/EOP detect, byte output.
module usb_rx_phy_ovs
  import usb_rx_pkg::*;
#(
  parameter int CLK_PER_BIT_FS = 4,
  parameter int CLK_PER_BIT_LS = 32,
  parameter int SYNC_MIN_ZEROS = 5
) (
  input  logic       clkout2,
  input  logic       reset,
  input  logic       io_usbDif,
  input  logic       io_usbDp,
  input  logic       io_usbDn,
  input  logic       io_rxEn,
  input  logic       io_lowSpeed,
  output logic [1:0] io_lineState,
  output logic       io_clkRecovered,
  output logic       io_rawData,
  output logic       io_rxActive,
  output logic       io_valid,
  output logic [7:0] io_data,
  output logic       io_rxError,
  output logic       io_eop
);
  localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);

  logic       dpS1, dnS1, difS1, dpS, dnS, difS;
  logic       se0, idleJ, lineJ, lineK, strobe, sampled, bitDec;
  logic       lsSel, eopPend, misalign;
  logic [2:0] ones, bitCnt;
  logic [ZW-1:0] zeros;
  logic [7:0] byteReg, nextByte;
  rxState_t   state;

  always_ff @(posedge clkout2 or posedge reset) begin
    if (reset) {dpS1, dnS1, difS1, dpS, dnS, difS} <= '0;
    else       {dpS1, dnS1, difS1, dpS, dnS, difS} <= {io_usbDp, io_usbDn, io_usbDif, dpS1, dnS1, difS1};
  end

  assign io_lineState = {dnS, dpS};
  assign se0      = (io_lineState == SE0);
  assign idleJ    = !se0 && (difS != io_lowSpeed);
  // LS swaps J and K on the single-ended pins.
  assign lineJ    = (io_lineState == (lsSel ? K_FS : J_FS));
  assign lineK    = (io_lineState == (lsSel ? J_FS : K_FS));
  assign sampled  = se0 ? 1'b0 : difS;
  assign bitDec   = ~(sampled ^ io_rawData);
  assign nextByte = {bitDec, byteReg[7:1]};

  usb_rx_dpll #(.CLK_PER_BIT_FS(CLK_PER_BIT_FS), .CLK_PER_BIT_LS(CLK_PER_BIT_LS)) uDpll (
    .clkout2(clkout2), .reset(reset), .difSync(difS), .se0(se0), .lowSpeed(lsSel),
    .strobe(strobe), .clkRecovered(io_clkRecovered)
  );

  always_ff @(posedge clkout2 or posedge reset) begin
    if (reset) begin
      state <= IDLE;  lsSel <= 1'b0;  io_rawData <= 1'b0;  ones <= '0;  zeros <= '0;
      bitCnt <= '0;  byteReg <= '0;  eopPend <= 1'b0;  misalign <= 1'b0;
      io_data <= '0;  io_valid <= 1'b0;  io_eop <= 1'b0;  io_rxError <= 1'b0;  io_rxActive <= 1'b0;
    end else begin
      io_valid   <= 1'b0;
      io_eop     <= 1'b0;
      io_rxError <= 1'b0;
      if (strobe) begin
        io_rawData <= sampled;
        ones       <= bitDec ? ((ones == 3'd7) ? ones : ones + 1'b1) : 3'd0;
      end
      if (!io_rxEn) begin
        state <= IDLE;  io_rxActive <= 1'b0;  lsSel <= io_lowSpeed;  zeros <= '0;  eopPend <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            lsSel <= io_lowSpeed;  zeros <= '0;  eopPend <= 1'b0;
            if (idleJ) state <= HUNT;
          end
          HUNT: if (strobe) begin
            if (se0) state <= IDLE;
            else if (!bitDec) begin
              if (zeros != ZW'(SYNC_MIN_ZEROS)) zeros <= zeros + 1'b1;
            end else if (zeros >= ZW'(SYNC_MIN_ZEROS)) begin
              state <= DATA;  io_rxActive <= 1'b1;  bitCnt <= '0;  ones <= '0;
            end else zeros <= '0;
          end
          DATA: if (strobe) begin
            if (eopPend) begin
              if (lineJ) begin
                io_eop <= 1'b1;  io_rxError <= misalign;  io_rxActive <= 1'b0;  state <= IDLE;
              end else if (lineK) begin
                io_rxError <= 1'b1;  io_rxActive <= 1'b0;  eopPend <= 1'b0;  state <= ERR;
              end
            end else if (se0) begin
              eopPend <= 1'b1;  misalign <= (bitCnt != 3'd0);
            end else if (ones == 3'(STUFF_RUN)) begin
              if (bitDec) begin
                io_rxError <= 1'b1;  io_rxActive <= 1'b0;  state <= ERR;
              end
            end else begin
              byteReg <= nextByte;
              bitCnt  <= bitCnt + 1'b1;
              if (bitCnt == 3'd7) begin
                io_data <= nextByte;  io_valid <= 1'b1;
              end
            end
          end
          ERR: if (strobe) begin
            if (se0)                  eopPend <= 1'b1;
            else if (eopPend && lineJ) state  <= IDLE;
            else if (lineK)           eopPend <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usb_rx_phy_ovs.sv
// Directed NRZI line stimulus with an event scoreboard; a negedge monitor pops and compares DUT strobes.
module tb_usb_rx_phy_ovs;
  logic       clkout2 = 1'b0, reset = 1'b1;
  logic       io_usbDif = 1'b1, io_usbDp = 1'b1, io_usbDn = 1'b0;
  logic       io_rxEn = 1'b0, io_lowSpeed = 1'b0;
  logic [1:0] io_lineState;
  logic       io_clkRecovered, io_rawData, io_rxActive, io_valid, io_rxError, io_eop;
  logic [7:0] io_data;

  usb_rx_phy_ovs dut (
    .clkout2(clkout2), .reset(reset), .io_usbDif(io_usbDif), .io_usbDp(io_usbDp), .io_usbDn(io_usbDn),
    .io_rxEn(io_rxEn), .io_lowSpeed(io_lowSpeed), .io_lineState(io_lineState),
    .io_clkRecovered(io_clkRecovered), .io_rawData(io_rawData), .io_rxActive(io_rxActive),
    .io_valid(io_valid), .io_data(io_data), .io_rxError(io_rxError), .io_eop(io_eop)
  );

  always #5 clkout2 = ~clkout2;

  typedef struct packed {logic v; logic e; logic r; logic [7:0] d;} ev_t;
  ev_t expQ[$];
  int  checks = 0, errors = 0;
  int  nBit = 4, ones = 0;
  logic ls = 1'b0, lvl = 1'b1, jitOn = 1'b0, jFlip = 1'b0;

  localparam int K = 0, J = 1, S0 = 2;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expV(input logic [7:0] d); expQ.push_back({1'b1, 1'b0, 1'b0, d}); endtask
  task automatic expE(input logic err);     expQ.push_back({1'b0, 1'b1, err, 8'h00}); endtask
  task automatic expR();                    expQ.push_back({1'b0, 1'b0, 1'b1, 8'h00}); endtask

  task automatic hold(input int sym, input int cyc);
    if (sym == S0) begin
      io_usbDp = 1'b0; io_usbDn = 1'b0;
    end else begin
      io_usbDif = (sym == J) ^ ls;
      io_usbDp  = (sym == J) ^ ls;
      io_usbDn  = !((sym == J) ^ ls);
    end
    repeat (cyc) @(negedge clkout2);
  endtask

  task automatic sendRaw(input logic b);
    int len;
    len = nBit;
    if (jitOn) begin
      len = jFlip ? nBit + 1 : nBit - 1;
      jFlip = ~jFlip;
    end
    if (!b) lvl = ~lvl;
    hold(lvl ? J : K, len);
  endtask

  task automatic sendBit(input logic b);
    sendRaw(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      sendRaw(1'b0);
      ones = 0;
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
  endtask

  task automatic sendSync(input int zeros);
    lvl = 1'b1;
    for (int i = 0; i < zeros; i++) sendRaw(1'b0);
    sendRaw(1'b1);
    ones = 0;
  endtask

  task automatic idle(input int bits);
    lvl = 1'b1;
    hold(J, bits * nBit);
  endtask

  task automatic sendEop();
    hold(S0, 2 * nBit);
    idle(4);
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, "_data"}, {8'h00, io_data}, 16'h0000);
    chk({tag, "_flags"}, {10'h0, io_valid, io_eop, io_rxError, io_rxActive, io_clkRecovered, io_rawData}, 16'h0000);
    chk({tag, "_linestate"}, {14'h0, io_lineState}, 16'h0000);
  endtask

  always @(negedge clkout2) begin
    if (!reset && (io_valid || io_eop || io_rxError)) begin
      ev_t a, e;
      a = {io_valid, io_eop, io_rxError, io_data};
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got v=%0b eop=%0b err=%0b data=%h, none required", a.v, a.e, a.r, a.d);
      end else begin
        e = expQ.pop_front();
        if (a.v !== e.v || a.e !== e.e || a.r !== e.r || (e.v && a.d !== e.d)) begin
          errors++;
          $display("FAIL event: got v=%0b eop=%0b err=%0b data=%h, required v=%0b eop=%0b err=%0b data=%h",
                   a.v, a.e, a.r, a.d, e.v, e.e, e.r, e.d);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clkout2);
    chkResetOutputs("reset");
    reset = 1'b0;
    io_rxEn = 1'b1;
    idle(6);

    // FS packet A5, 3C
    sendSync(7);
    expV(8'hA5); sendByte(8'hA5);
    chk("active_in_packet", {15'h0, io_rxActive}, 16'h0001);
    expV(8'h3C); sendByte(8'h3C);
    expE(1'b0);  sendEop();
    chk("active_after_eop", {15'h0, io_rxActive}, 16'h0000);

    // stuffed FF FF
    sendSync(7);
    expV(8'hFF); expV(8'hFF);
    sendByte(8'hFF); sendByte(8'hFF);
    expE(1'b0); sendEop();

    // stuff violation: seventh consecutive 1
    sendSync(7);
    expR();
    for (int i = 0; i < 7; i++) sendRaw(1'b1);
    repeat (2) @(negedge clkout2);
    chk("active_after_stuff_err", {15'h0, io_rxActive}, 16'h0000);
    sendRaw(1'b0); sendRaw(1'b1); sendRaw(1'b0);
    sendEop();

    // SYNC with exactly five zeros
    sendSync(5);
    expV(8'h3C); sendByte(8'h3C);
    chk("active_sync5", {15'h0, io_rxActive}, 16'h0001);
    expE(1'b0); sendEop();

    // SYNC with four zeros is not accepted
    sendSync(4);
    sendByte(8'hA5);
    chk("active_sync4", {15'h0, io_rxActive}, 16'h0000);
    sendEop();

    // EOP after 12 data bits
    sendSync(7);
    expV(8'h5A); sendByte(8'h5A);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
    expE(1'b1); sendEop();

    // rxEn dropped mid-byte
    sendSync(7);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    chk("active_before_rxen_drop", {15'h0, io_rxActive}, 16'h0001);
    io_rxEn = 1'b0;
    @(negedge clkout2);
    chk("active_after_rxen_drop", {15'h0, io_rxActive}, 16'h0000);
    idle(4);

    // low speed, clean then with alternating +/-1 cycle edge jitter
    ls = 1'b1; io_lowSpeed = 1'b1; nBit = 32;
    idle(2);
    io_rxEn = 1'b1;
    idle(4);
    sendSync(7);
    expV(8'h69); sendByte(8'h69);
    expE(1'b0); sendEop();
    jitOn = 1'b1;
    sendSync(7);
    expV(8'h69); sendByte(8'h69);
    jitOn = 1'b0;
    expE(1'b0); sendEop();

    // back to full speed, then reset mid-byte
    io_rxEn = 1'b0; ls = 1'b0; io_lowSpeed = 1'b0; nBit = 4;
    idle(2);
    io_rxEn = 1'b1;
    idle(6);
    sendSync(7);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b0); sendBit(1'b1);
    #1 reset = 1'b1;
    #1 chkResetOutputs("midreset");
    repeat (2) @(negedge clkout2);
    reset = 1'b0;
    idle(6);
    sendSync(7);
    expV(8'h42); sendByte(8'h42);
    expE(1'b0); sendEop();

    for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge clkout2);
    chk("scoreboard_drained", 16'(expQ.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
